// File: rtl/hello_seg_decoder.sv
// rtl/hello_seg_decoder.sv - 7-segment pattern decoder with HELLO word detector
//
// Purpose:
//    Decodes a stream of active-low 7-segment patterns (one digit per valid
//    beat) back into 3-bit character codes and detects the word H-E-L-L-O in
//    the decoded stream, counting detections in a saturating counter.
//
// Optional feature macro: SEG_ERR_STICKY_EN
//    Defined   : o_seg_err sets on the first invalid pattern and holds until reset.
//    Undefined : o_seg_err is a one-cycle pulse per invalid beat.
//
// Ports:
//    i_clk          rising-edge clock
//    i_reset        synchronous active-high reset
//    i_seg_in       segment pattern, bit 0 = a ... bit 6 = g, active-low
//    i_seg_valid    i_seg_in is sampled this cycle
//    o_code_out     decoded character code (H=000 E=001 L=010 O=011 blank=100 invalid=111)
//    o_code_valid   o_code_out is valid this cycle
//    o_found        one-cycle pulse on completion of HELLO
//    o_word_count   saturating count of HELLO words detected
//    o_seg_err      unrecognised pattern seen
module hello_seg_decoder #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [6:0]           i_seg_in,
   input  logic                 i_seg_valid,
   output logic [2:0]           o_code_out,
   output logic                 o_code_valid,
   output logic                 o_found,
   output logic [CNT_WIDTH-1:0] o_word_count,
   output logic                 o_seg_err
);

   // Patterns held as {g,f,e,d,c,b,a}, i.e. the a..g strings reversed.
   localparam logic [6:0] SEG_H     = 7'b0001001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_L     = 7'b1000111;
   localparam logic [6:0] SEG_O     = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [2:0] CODE_H     = 3'b000;
   localparam logic [2:0] CODE_E     = 3'b001;
   localparam logic [2:0] CODE_L     = 3'b010;
   localparam logic [2:0] CODE_O     = 3'b011;
   localparam logic [2:0] CODE_BLANK = 3'b100;
   localparam logic [2:0] CODE_INV   = 3'b111;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_H    = 3'd1,
      S_HE   = 3'd2,
      S_HEL  = 3'd3,
      S_HELL = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_found_next;
   logic [2:0]           w_code;
   logic [2:0]           r_code;
   logic                 r_code_valid;
   logic                 r_found;
   logic [CNT_WIDTH-1:0] r_word_count;
   logic                 r_seg_err;

   always_comb begin
      w_code = CODE_INV;
      case (i_seg_in)
         SEG_H:     w_code = CODE_H;
         SEG_E:     w_code = CODE_E;
         SEG_L:     w_code = CODE_L;
         SEG_O:     w_code = CODE_O;
         SEG_BLANK: w_code = CODE_BLANK;
         default:   w_code = CODE_INV;
      endcase
   end

   // Any mismatch that is itself an H restarts the match at S_H; blank and
   // invalid codes fall into the generic "else IDLE" path.
   always_comb begin
      w_state_next = r_state;
      w_found_next = 1'b0;
      if (i_seg_valid) begin
         w_state_next = (w_code == CODE_H) ? S_H : IDLE;
         case (r_state)
            S_H:    if (w_code == CODE_E) w_state_next = S_HE;
            S_HE:   if (w_code == CODE_L) w_state_next = S_HEL;
            S_HEL:  if (w_code == CODE_L) w_state_next = S_HELL;
            S_HELL: if (w_code == CODE_O) begin
                       w_state_next = IDLE;
                       w_found_next = 1'b1;
                    end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_code       <= CODE_BLANK;
         r_code_valid <= 1'b0;
         r_found      <= 1'b0;
         r_word_count <= '0;
         r_seg_err    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_code_valid <= i_seg_valid;
         r_found      <= w_found_next;
         if (i_seg_valid) begin
            r_code <= w_code;
         end
         if (w_found_next && (r_word_count != '1)) begin
            r_word_count <= r_word_count + 1'b1;
         end
`ifdef SEG_ERR_STICKY_EN
         if (i_seg_valid && (w_code == CODE_INV)) begin
            r_seg_err <= 1'b1;
         end
`else
         r_seg_err <= i_seg_valid && (w_code == CODE_INV);
`endif
      end
   end

   assign o_code_out   = r_code;
   assign o_code_valid = r_code_valid;
   assign o_found      = r_found;
   assign o_word_count = r_word_count;
   assign o_seg_err    = r_seg_err;

endmodule

// File: tb/tb_hello_seg_decoder.sv
// tb/tb_hello_seg_decoder.sv - scoreboard bench for hello_seg_decoder
module tb_hello_seg_decoder;

   logic       clk;
   logic       reset;
   logic [6:0] seg_in;
   logic       seg_valid;
   logic [2:0] code_out,  code_out2;
   logic       code_valid, code_valid2;
   logic       found,     found2;
   logic [7:0] word_count;
   logic [1:0] word_count2;
   logic       seg_err,   seg_err2;

   hello_seg_decoder #(.CNT_WIDTH(8)) dut (
      .i_clk(clk), .i_reset(reset), .i_seg_in(seg_in), .i_seg_valid(seg_valid),
      .o_code_out(code_out), .o_code_valid(code_valid), .o_found(found),
      .o_word_count(word_count), .o_seg_err(seg_err)
   );

   hello_seg_decoder #(.CNT_WIDTH(2)) dut2 (
      .i_clk(clk), .i_reset(reset), .i_seg_in(seg_in), .i_seg_valid(seg_valid),
      .o_code_out(code_out2), .o_code_valid(code_valid2), .o_found(found2),
      .o_word_count(word_count2), .o_seg_err(seg_err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int code;
      int fnd;
      int err;
      int cnt8;
      int cnt2;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state (spec-level: a..g strings, sliding window of codes)
   logic [0:6] tbl [5] = '{7'b1001000, 7'b0110000, 7'b1110001, 7'b0000001, 7'b1111111};
   int  hist[$];
   int  m_cnt8, m_cnt2, m_sticky;
   bit  mon_en = 0;
   bit  expect_reset = 0;

   localparam logic [0:6] P_H = 7'b1001000;
   localparam logic [0:6] P_E = 7'b0110000;
   localparam logic [0:6] P_L = 7'b1110001;
   localparam logic [0:6] P_O = 7'b0000001;
   localparam logic [0:6] P_B = 7'b1111111;
   localparam logic [0:6] P_Z = 7'b0000000;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] to_port(input logic [0:6] p);
      logic [6:0] r;
      for (int i = 0; i < 7; i++) r[i] = p[i];
      return r;
   endfunction

   function automatic int decode(input logic [0:6] p);
      for (int i = 0; i < 5; i++) if (p == tbl[i]) return i;
      return 7;
   endfunction

   task automatic beat(input logic [0:6] p, input bit v);
      exp_t e;
      @(posedge clk);
      #1;
      seg_in    = to_port(p);
      seg_valid = v;
      if (v) begin
         e.code = decode(p);
         hist.push_back(e.code);
         if (hist.size() > 5) void'(hist.pop_front());
         e.fnd = (hist.size() == 5 && hist[0] == 0 && hist[1] == 1 &&
                  hist[2] == 2 && hist[3] == 2 && hist[4] == 3) ? 1 : 0;
         if (e.fnd == 1) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
         end
         if (e.code == 7) m_sticky = 1;
`ifdef SEG_ERR_STICKY_EN
         e.err = m_sticky;
`else
         e.err = (e.code == 7) ? 1 : 0;
`endif
         e.cnt8 = m_cnt8;
         e.cnt2 = m_cnt2;
         q.push_back(e);
      end
   endtask

   task automatic send_word(input logic [0:6] w[$], input int gap);
      foreach (w[i]) begin
         beat(w[i], 1'b1);
         for (int g = 0; g < gap; g++) beat(P_B, 1'b0);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset     = 1'b1;
      seg_valid = 1'b1;       // reset must win over a simultaneous beat
      seg_in    = to_port(P_H);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      seg_valid = 1'b0;
      hist.delete();
      m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
      expect_reset = 1;
   endtask

   // Monitor
   int last_code = 4, last_err = 0, last_c8 = 0, last_c2 = 0;
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (expect_reset) begin
            chk("rst_code",  code_out, 4);
            chk("rst_valid", code_valid, 0);
            chk("rst_found", found, 0);
            chk("rst_count", word_count, 0);
            chk("rst_err",   seg_err, 0);
            chk("rst_count2", word_count2, 0);
            last_code = 4; last_err = 0; last_c8 = 0; last_c2 = 0;
            expect_reset = 0;
         end else if (code_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = q.pop_front();
               chk("code",   code_out, e.code);
               chk("found",  found, e.fnd);
               chk("seg_err", seg_err, e.err);
               chk("count",  word_count, e.cnt8);
               chk("count_sat", word_count2, e.cnt2);
               chk("code2",  code_out2, e.code);
               chk("valid2", code_valid2, 1);
               last_code = e.code; last_err = e.err; last_c8 = e.cnt8; last_c2 = e.cnt2;
            end
         end else begin
            chk("idle_hold_code", code_out, last_code);
            chk("idle_found", found, 0);
            chk("idle_count", word_count, last_c8);
            chk("idle_count2", word_count2, last_c2);
`ifdef SEG_ERR_STICKY_EN
            chk("idle_err", seg_err, last_err);
`else
            chk("idle_err", seg_err, 0);
`endif
         end
      end
   end

   logic [0:6] hello[$] = '{7'b1001000, 7'b0110000, 7'b1110001, 7'b1110001, 7'b0000001};

   initial begin
      logic [0:6] p;
      int r;
      reset = 1'b1; seg_valid = 1'b0; seg_in = 7'h7F;
      m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      expect_reset = 1;
      mon_en = 1;

      send_word(hello, 0);
      beat(P_B, 1'b0);
      send_word('{P_H, P_E, P_L, P_B, P_L, P_O}, 0);
      send_word('{P_H, P_H, P_E, P_L, P_L, P_O}, 2);
      beat(P_Z, 1'b1);
      send_word(hello, 0);
      beat(P_B, 1'b0);
      for (int k = 0; k < 5; k++) send_word(hello, 0);
      send_word('{P_H, P_E, P_L}, 0);
      do_reset();
      send_word('{P_L, P_O}, 0);
      beat(P_B, 1'b0);

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 4) begin
            beat(tbl[r], $urandom_range(0, 3) != 0);
         end else if (r == 5) begin
            p = 7'($urandom);
            beat(p, 1'b1);
         end else if (r == 9 && n % 50 == 0) begin
            do_reset();
         end else begin
            send_word(hello, $urandom_range(0, 1));
         end
      end
      beat(P_B, 1'b0);
      beat(P_B, 1'b0);
      @(posedge clk);
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
